// File: rtl/rr_arb_fwdpipe.sv
// rr_arb_fwdpipe: N upstream valid/ready streams share one registered output stage.
// Round-robin grant with packet lock; m_* are flops, the ready path is combinational.
module rr_arb_fwdpipe #(
  parameter int N       = 4,
  parameter int DWIDTH  = 32,
  parameter int IDWIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          s_valid,
  input  logic [N*DWIDTH-1:0]   s_data,
  input  logic [N-1:0]          s_last,
  output logic [N-1:0]          s_ready,
  output logic                  m_valid,
  output logic [DWIDTH-1:0]     m_data,
  output logic                  m_last,
  output logic [IDWIDTH-1:0]    m_id,
  input  logic                  m_ready,
  output logic                  busy
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [IDWIDTH:0]   N_EXT   = (IDWIDTH+1)'(N);
  localparam logic [IDWIDTH-1:0] LAST_ID = IDWIDTH'(N - 1);

  state_t              state, state_next;
  logic [IDWIDTH-1:0]  ptr, ptr_next;
  logic [IDWIDTH-1:0]  owner, owner_next;
  logic [IDWIDTH-1:0]  grant, sel;
  logic [IDWIDTH:0]    scan;
  logic                grant_vld, req, take, xfer, sel_last;
  logic [DWIDTH-1:0]   sel_data;

  // The output stage can take a beat when it is empty or being drained this cycle.
  assign take = ~m_valid | m_ready;
  assign busy = (state == LOCKED);

  // Locked packets keep their owner; otherwise the round-robin winner is served.
  assign sel  = busy ? owner : grant;
  assign req  = busy | grant_vld;
  assign xfer = |(s_valid & s_ready);

  // Round-robin search: first valid requester at or after ptr, wrapping at N.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan      = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr} + (IDWIDTH+1)'(k);
      if (scan >= N_EXT) scan = scan - N_EXT;
      if (!grant_vld && s_valid[scan[IDWIDTH-1:0]]) begin
        grant_vld = 1'b1;
        grant     = scan[IDWIDTH-1:0];
      end
    end
  end

  // Route ready to the selected requester and mux its data/last toward the stage.
  always_comb begin
    s_ready  = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == IDWIDTH'(i)) begin
        s_ready[i] = req & take;
        sel_data   = s_data[i*DWIDTH +: DWIDTH];
        sel_last   = s_last[i];
      end
    end
  end

  // Lock on a non-final beat; release and advance the pointer past the winner on the last beat.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    owner_next = owner;
    if (xfer) begin
      if (sel_last) begin
        state_next = IDLE;
        ptr_next   = (sel == LAST_ID) ? '0 : sel + IDWIDTH'(1);
      end else begin
        state_next = LOCKED;
        owner_next = sel;
      end
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      owner <= owner_next;
    end
  end

  // Output stage control: load on transfer, empty when drained with nothing new, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_id    <= '0;
    end else if (xfer) begin
      m_valid <= 1'b1;
      m_last  <= sel_last;
      m_id    <= sel;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Output data carries no reset; it is only meaningful while m_valid is set.
  always_ff @(posedge clk) begin
    if (xfer) m_data <= sel_data;
  end

endmodule
